// File: rtl/trace_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trace_readout_ctrl
// Purpose  : Drains the commit-trace snapshot register into a 32-bit
//            valid/ready word stream. A held record is copied into a shadow
//            buffer and the producer is released at once, so the next commit
//            can be captured while the current record drains.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   s_axi_aclk    in   clock
//   s_axi_areset  in   synchronous reset, active-high
//   enable        in   permits new captures (does not abort a record)
//   short_mode    in   1 = send SHORT_W/WORD_W words, 0 = DATA_W/WORD_W
//   rec_full      in   producer holds a valid record (level)
//   rec_data      in   producer record, stable while rec_full = 1
//   commit_valid  in   core commit strobe, used for drop accounting only
//   data_next     out  one-cycle release pulse to the producer
//   m_word        out  stream data word
//   m_valid       out  stream valid
//   m_ready       in   stream ready
//   m_last        out  final word of a record
//   busy          out  FSM is not idle
//   rec_count     out  records fully delivered (wraps)
//   drop_count    out  commits lost while producer was full (saturates)
// ============================================================================
module trace_readout_ctrl #(
  parameter int DATA_W  = 1664,
  parameter int WORD_W  = 32,
  parameter int SHORT_W = 512
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_areset,
  input  logic              enable,
  input  logic              short_mode,
  input  logic              rec_full,
  input  logic [DATA_W-1:0] rec_data,
  input  logic              commit_valid,
  output logic              data_next,
  output logic [WORD_W-1:0] m_word,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic [31:0]       rec_count,
  output logic [15:0]       drop_count
);

  localparam int FULL_WORDS  = DATA_W / WORD_W;
  localparam int SHORT_WORDS = SHORT_W / WORD_W;
  // Wide enough to hold the word total itself, not just the last index.
  localparam int CNT_W       = $clog2(FULL_WORDS + 1);

  localparam logic [CNT_W-1:0] FULL_LEN  = CNT_W'(FULL_WORDS);
  localparam logic [CNT_W-1:0] SHORT_LEN = CNT_W'(SHORT_WORDS);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic              data_next_q, data_next_d;
  logic [31:0]       rec_count_q, rec_count_d;
  logic [15:0]       drop_count_q, drop_count_d;

  logic              w_sending;
  logic              w_capture;
  logic              w_xfer;
  logic              w_is_last;
  logic              w_last_xfer;
  logic              w_drop_inc;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_words [FULL_WORDS];

  // --------------------------------------------------------------------------
  // Word view of the shadow buffer: word 0 is the least significant slice.
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < FULL_WORDS; gi++) begin : g_word
    assign w_words[gi] = shadow_q[gi*WORD_W +: WORD_W];
  end

  always_comb begin
    w_word = '0;
    for (int i = 0; i < FULL_WORDS; i++) begin
      if (idx_q == CNT_W'(i)) begin
        w_word = w_words[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  assign w_sending   = (state_q == ST_SEND);
  // rec_full is only looked at in IDLE; the stale flag seen right after the
  // release pulse therefore cannot trigger a second capture.
  assign w_capture   = (state_q == ST_IDLE) && enable && rec_full;
  assign w_xfer      = w_sending && m_ready;
  assign w_is_last   = (idx_q == (total_q - ONE));
  assign w_last_xfer = w_xfer && w_is_last;
  // The release cycle itself is not a loss: the producer is being emptied.
  assign w_drop_inc  = commit_valid && rec_full && !data_next_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    total_d      = total_q;
    data_next_d  = 1'b0;
    rec_count_d  = rec_count_q;
    drop_count_d = drop_count_q;

    case (state_q)
      ST_IDLE: begin
        if (w_capture) begin
          shadow_d    = rec_data;
          total_d     = short_mode ? SHORT_LEN : FULL_LEN;
          idx_d       = '0;
          data_next_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (w_last_xfer) begin
          rec_count_d = rec_count_q + 32'd1;
          state_d     = ST_IDLE;
        end else if (w_xfer) begin
          idx_d = idx_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (w_drop_inc && (drop_count_q != DROP_MAX)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      idx_q        <= '0;
      total_q      <= '0;
      data_next_q  <= 1'b0;
      rec_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      total_q      <= total_d;
      data_next_q  <= data_next_d;
      rec_count_q  <= rec_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: the stream is driven straight from registers, so word, valid
  // and last are inherently stable while the sink withholds ready.
  // --------------------------------------------------------------------------
  assign data_next  = data_next_q;
  assign m_valid    = w_sending;
  assign m_word     = w_sending ? w_word : '0;
  assign m_last     = w_sending && w_is_last;
  assign busy       = w_sending;
  assign rec_count  = rec_count_q;
  assign drop_count = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_trace_readout_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trace_readout_ctrl
// Purpose  : Self-checking bench for trace_readout_ctrl. Expected words are
//            queued when a capture is driven and compared as the stream
//            delivers them; a record table drives the main cases and
//            hand-written sequences cover the multi-cycle corners.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trace_readout_ctrl;

  localparam int DATA_W  = 1664;
  localparam int WORD_W  = 32;
  localparam int SHORT_W = 512;
  localparam int FULL_N  = DATA_W / WORD_W;
  localparam int SHORT_N = SHORT_W / WORD_W;

  logic              clk;
  logic              s_axi_areset;
  logic              enable;
  logic              short_mode;
  logic              rec_full;
  logic [DATA_W-1:0] rec_data;
  logic              commit_valid;
  logic              data_next;
  logic [WORD_W-1:0] m_word;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;
  logic              busy;
  logic [31:0]       rec_count;
  logic [15:0]       drop_count;

  trace_readout_ctrl #(
    .DATA_W (DATA_W),
    .WORD_W (WORD_W),
    .SHORT_W(SHORT_W)
  ) dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(s_axi_areset),
    .enable      (enable),
    .short_mode  (short_mode),
    .rec_full    (rec_full),
    .rec_data    (rec_data),
    .commit_valid(commit_valid),
    .data_next   (data_next),
    .m_word      (m_word),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .busy        (busy),
    .rec_count   (rec_count),
    .drop_count  (drop_count)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic        short_mode;
    logic [31:0] base;
    int          ready_mode;  // 0 always, 1 pattern 1,0,0, 2 random, 3 never
    int          exp_total;
  } vec_t;

  exp_t  sb_q[$];
  vec_t  vecs[4];
  int    checks;
  int    errors;
  int    words_seen;
  int    lasts_seen;
  int    ready_mode;
  int    exp_rec;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sink ready generator
  initial begin
    int rp;
    rp      = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       begin m_ready = (rp % 3 == 0); rp++; end
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Stream monitor: scoreboard pop plus stability under backpressure
  initial begin
    logic        hold;
    logic [31:0] hold_word;
    logic        hold_last;
    exp_t        e;
    hold = 1'b0;
    hold_word = '0;
    hold_last = 1'b0;
    forever begin
      @(negedge clk);
      if (s_axi_areset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold valid", 64'(m_valid), 64'd1);
          chk("hold word", 64'(m_word), 64'(hold_word));
          chk("hold last", 64'(m_last), 64'(hold_last));
        end
        if (m_valid && m_ready) begin
          words_seen++;
          if (m_last) lasts_seen++;
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb empty: got word %0h, expected no transfer", m_word);
          end else begin
            e = sb_q.pop_front();
            chk("sb word", 64'(m_word), 64'(e.word));
            chk("sb last", 64'(m_last), 64'(e.last));
          end
        end
        hold      = m_valid && !m_ready;
        hold_word = m_word;
        hold_last = m_last;
      end
    end
  end

  task automatic load_data(input logic [31:0] base);
    for (int k = 0; k < FULL_N; k++) begin
      rec_data[k*WORD_W +: WORD_W] = base + 32'(k);
    end
  endtask

  task automatic push_expected(input logic sm, input logic [31:0] base);
    int tot;
    exp_t e;
    tot = sm ? SHORT_N : FULL_N;
    for (int k = 0; k < tot; k++) begin
      e.last = (k == tot - 1);
      e.word = base + 32'(k);
      sb_q.push_back(e);
    end
  endtask

  // Drives a record at cycle T and returns at T+1 with the release checked.
  task automatic start_capture(input logic sm, input logic [31:0] base);
    load_data(base);
    short_mode = sm;
    rec_full   = 1'b1;
    tick();
    chk("data_next at T+1", 64'(data_next), 64'd1);
    chk("m_valid at T+1", 64'(m_valid), 64'd1);
    chk("word0 at T+1", 64'(m_word), 64'(base));
    push_expected(sm, base);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: busy=%0d pending=%0d, required idle", busy, sb_q.size());
    end
  endtask

  task automatic run_record(input vec_t v);
    int n;
    int w0;
    int l0;
    w0 = words_seen;
    l0 = lasts_seen;
    start_capture(v.short_mode, v.base);
    short_mode = ~v.short_mode;  // must not affect the record in flight
    tick();
    rec_full = 1'b0;
    chk("data_next one cycle", 64'(data_next), 64'd0);
    n = 1;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    if (v.ready_mode == 0) chk("done latency", 64'(n), 64'(v.exp_total));
    chk("busy after record", 64'(busy), 64'd0);
    drain(100);
    exp_rec++;
    chk("rec_count", 64'(rec_count), 64'(exp_rec));
    chk("word count", 64'(words_seen - w0), 64'(v.exp_total));
    chk("last count", 64'(lasts_seen - l0), 64'd1);
  endtask

  initial begin
    int n;
    int w0;
    int l0;
    int bad;

    checks       = 0;
    errors       = 0;
    words_seen   = 0;
    lasts_seen   = 0;
    exp_rec      = 0;
    ready_mode   = 0;
    s_axi_areset = 1'b1;
    enable       = 1'b1;
    short_mode   = 1'b0;
    rec_full     = 1'b0;
    rec_data     = '0;
    commit_valid = 1'b0;

    vecs[0] = '{short_mode: 1'b0, base: 32'hA000_0000, ready_mode: 0, exp_total: FULL_N};
    vecs[1] = '{short_mode: 1'b1, base: 32'hB000_0000, ready_mode: 1, exp_total: SHORT_N};
    vecs[2] = '{short_mode: 1'b0, base: 32'hC000_0100, ready_mode: 2, exp_total: FULL_N};
    vecs[3] = '{short_mode: 1'b1, base: 32'hD000_0FF0, ready_mode: 0, exp_total: SHORT_N};

    // Reset state
    repeat (3) tick();
    chk("rst data_next", 64'(data_next), 64'd0);
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst m_last", 64'(m_last), 64'd0);
    chk("rst m_word", 64'(m_word), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst rec_count", 64'(rec_count), 64'd0);
    chk("rst drop_count", 64'(drop_count), 64'd0);
    s_axi_areset = 1'b0;
    tick();

    // Table-driven records
    for (int i = 0; i < 4; i++) begin
      ready_mode = vecs[i].ready_mode;
      tick();
      run_record(vecs[i]);
    end

    // Back-to-back: producer refills right after its release
    ready_mode = 0;
    tick();
    l0 = lasts_seen;
    start_capture(1'b0, 32'hE000_0000);
    tick();
    load_data(32'hF000_0000);
    n = 1;
    while (!data_next && n < 200) begin
      tick();
      n++;
    end
    chk("b2b second release cycle", 64'(n), 64'(FULL_N + 1));
    chk("b2b word0", 64'(m_word), 64'hF000_0000);
    push_expected(1'b0, 32'hF000_0000);
    tick();
    rec_full = 1'b0;
    drain(200);
    exp_rec += 2;
    chk("b2b rec_count", 64'(rec_count), 64'(exp_rec));
    chk("b2b last count", 64'(lasts_seen - l0), 64'd2);

    // Enable dropped mid-record
    w0 = words_seen;
    start_capture(1'b0, 32'h1234_0000);
    tick();
    rec_full = 1'b0;
    repeat (9) tick();
    chk("en word10", 64'(m_word), 64'h1234_000A);
    enable = 1'b0;
    drain(200);
    exp_rec++;
    chk("en rec_count", 64'(rec_count), 64'(exp_rec));
    chk("en word count", 64'(words_seen - w0), 64'(FULL_N));
    rec_full = 1'b1;
    bad = 0;
    repeat (6) begin
      tick();
      if (data_next || busy) bad++;
    end
    chk("en no capture", 64'(bad), 64'd0);
    rec_full = 1'b0;
    enable   = 1'b1;
    tick();

    // Drop accounting with saturation
    chk("drop start", 64'(drop_count), 64'd0);
    ready_mode = 3;
    tick();
    start_capture(1'b0, 32'h7700_0000);
    tick();
    for (int i = 0; i < 5; i++) begin
      commit_valid = 1'b1;
      tick();
      commit_valid = 1'b0;
      tick();
    end
    chk("drop count 5", 64'(drop_count), 64'd5);
    commit_valid = 1'b1;
    repeat (16'hFFFE - 5) tick();
    chk("drop count FFFE", 64'(drop_count), 64'hFFFE);
    repeat (3) tick();
    chk("drop saturate", 64'(drop_count), 64'hFFFF);
    commit_valid = 1'b0;
    rec_full     = 1'b0;
    ready_mode   = 0;
    drain(200);
    exp_rec++;
    chk("drop rec_count", 64'(rec_count), 64'(exp_rec));

    // Reset mid-record, then a fresh capture from word 0
    tick();
    start_capture(1'b0, 32'h5500_0000);
    repeat (20) tick();
    chk("rstmid word20", 64'(m_word), 64'h5500_0014);
    s_axi_areset = 1'b1;
    tick();
    chk("rstmid m_valid", 64'(m_valid), 64'd0);
    chk("rstmid busy", 64'(busy), 64'd0);
    chk("rstmid rec_count", 64'(rec_count), 64'd0);
    chk("rstmid data_next", 64'(data_next), 64'd0);
    chk("rstmid drop_count", 64'(drop_count), 64'd0);
    sb_q.delete();
    exp_rec      = 0;
    s_axi_areset = 1'b0;
    tick();
    chk("rstmid restart data_next", 64'(data_next), 64'd1);
    chk("rstmid restart word0", 64'(m_word), 64'h5500_0000);
    push_expected(1'b0, 32'h5500_0000);
    tick();
    rec_full = 1'b0;
    drain(200);
    exp_rec++;
    chk("rstmid rec_count after", 64'(rec_count), 64'(exp_rec));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
